// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: FSM state encoding,
// the default pattern and a counter width helper.
package seq_gen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] SEQ_DEF_PAT = 5'b11110;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Parallel-load, shift-left register with an MSB tap; load wins over shift.
module seq_gen_shreg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         msb
);

  logic [W-1:0] q_r;

  // Pattern storage: zeros on clear, then load or shift one place left.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= din;
    end else if (shift) begin
      q_r <= {q_r[W-2:0], 1'b0};
    end else begin
      q_r <= q_r;
    end
  end

  assign q   = q_r;
  assign msb = q_r[W-1];

endmodule

// File: rtl/moore_seq_gen.sv
// Moore serial pattern transmitter: MSB-first, REPEAT times with GAP_CYC idle
// cycles between repetitions. Define SEQ_GEN_LOOP_EN to add the `loop` input.
module moore_seq_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SEQ_DEF_PAT),
  parameter int               REPEAT  = 1,
  parameter int               GAP_CYC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_def,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop,
`endif
  input  logic [PAT_W-1:0] pat_in,
  input  logic             stop,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_w(PAT_W - 1);
  localparam int RW = cnt_w(REPEAT - 1);
  localparam int GW = cnt_w(GAP_CYC);

  logic [1:0]       state_r, state_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [RW-1:0]    rep_cnt_r, rep_cnt_s;
  logic [GW-1:0]    gap_cnt_r, gap_cnt_s;
  logic [PAT_W-1:0] pat_r, pat_s;
  logic             loop_r, loop_s;
  logic             stop_pend_r, stop_pend_s;
  logic             x_r, x_s;
  logic             x_valid_r, x_valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  logic             loop_in_s;
  logic             load_s, shift_s;
  logic [PAT_W-1:0] load_val_s;
  logic [PAT_W-1:0] shq_s;
  logic             shmsb_s;
  logic             last_bit_s, more_s, abort_s;

`ifdef SEQ_GEN_LOOP_EN
  assign loop_in_s = loop;
`else
  assign loop_in_s = 1'b0;
`endif

  seq_gen_shreg #(.W(PAT_W)) u_shreg (
    .clk   (clk),
    .clr   (reset),
    .load  (load_s),
    .shift (shift_s),
    .din   (load_val_s),
    .q     (shq_s),
    .msb   (shmsb_s)
  );

  // Next-state, counter and next-output decode.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    rep_cnt_s   = rep_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    pat_s       = pat_r;
    loop_s      = loop_r;
    stop_pend_s = stop_pend_r | (busy_r & stop);
    load_s      = 1'b0;
    shift_s     = 1'b0;
    load_val_s  = pat_r;
    last_bit_s  = (bit_cnt_r == BW'(PAT_W - 1));
    more_s      = loop_r | ((int'(rep_cnt_r) + 1) < REPEAT);
    abort_s     = stop_pend_r | stop;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_val_s  = use_def ? DEF_PAT : pat_in;
          pat_s       = load_val_s;
          load_s      = 1'b1;
          bit_cnt_s   = {BW{1'b0}};
          rep_cnt_s   = {RW{1'b0}};
          gap_cnt_s   = {GW{1'b0}};
          loop_s      = loop_in_s;
          stop_pend_s = 1'b0;
          state_s     = ST_SHIFT;
        end else begin
          stop_pend_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          if (more_s && !abort_s) begin
            // Reload here so the next repetition starts with no bubble.
            load_s    = 1'b1;
            bit_cnt_s = {BW{1'b0}};
            gap_cnt_s = {GW{1'b0}};
            if (rep_cnt_r != {RW{1'b1}}) begin
              rep_cnt_s = rep_cnt_r + RW'(1);
            end else begin
              rep_cnt_s = rep_cnt_r;
            end
            state_s = (GAP_CYC > 0) ? ST_GAP : ST_SHIFT;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          shift_s   = 1'b1;
          bit_cnt_s = bit_cnt_r + BW'(1);
        end
      end
      ST_GAP: begin
        if (abort_s) begin
          state_s = ST_DONE;
        end else if (gap_cnt_r == GW'(GAP_CYC - 1)) begin
          gap_cnt_s = {GW{1'b0}};
          state_s   = ST_SHIFT;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end
      ST_DONE: begin
        stop_pend_s = 1'b0;
        state_s     = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    x_valid_s = (state_s == ST_SHIFT);
    busy_s    = (state_s != ST_IDLE);
    done_s    = (state_s == ST_DONE);
    // x is registered, so predict the bit the shift register will present.
    if (state_s == ST_SHIFT) begin
      if (load_s) begin
        x_s = load_val_s[PAT_W-1];
      end else if (shift_s) begin
        x_s = shq_s[PAT_W-2];
      end else begin
        x_s = shmsb_s;
      end
    end else begin
      x_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= {BW{1'b0}};
      rep_cnt_r   <= {RW{1'b0}};
      gap_cnt_r   <= {GW{1'b0}};
      pat_r       <= {PAT_W{1'b0}};
      loop_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      x_r         <= 1'b0;
      x_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      rep_cnt_r   <= rep_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      pat_r       <= pat_s;
      loop_r      <= loop_s;
      stop_pend_r <= stop_pend_s;
      x_r         <= x_s;
      x_valid_r   <= x_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign x       = x_r;
  assign x_valid = x_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule
